serial_to_parallel: RTL and testbench

Upstream feeder for the team's parallel load register. Collects a serial bit stream into a WIDTH-bit word. Presents the word on data_out with a one-cycle load pulse, so it drives the register's data_in/load directly. Supports gapped input via bit_valid and mid-word abort.

---
 rtl/serial_to_parallel_pkg.sv | 24 ++
 rtl/serial_to_parallel_bit_counter.sv | 44 ++++
 rtl/serial_to_parallel.sv | 163 ++++++++++++++++
 tb/tb_serial_to_parallel.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the serial_to_parallel deserializer: FSM state
// encoding, default parameter values and a constant-evaluable clog2.
package serial_to_parallel_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    // Default word geometry
    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_MSB_FIRST = 1;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_to_parallel_bit_counter.sv
// Modulo-WIDTH bit counter for the deserializer. 'terminal' flags the
// increment that completes a word; the counter returns to zero on it.
module bit_counter
    import serial_to_parallel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          terminal
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign terminal = inc && (count_q == LAST);
    assign count    = count_q;

    // Next count: clear dominates, otherwise advance and wrap on the last bit
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = terminal ? '0 : count_q + 1'b1;
        end
    end

    // Count register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer feeding a parallel load register.
// Collects WIDTH qualified bits, then presents the word on data_out with a
// one-cycle load pulse. Gaps (bit_valid=0) are allowed; abort drops a
// partial word.
// Optional build macro SERIAL_TO_PARALLEL_PARITY_EN: an even parity bit is
// expected after each word; a mismatch drops the word and pulses parity_err.
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             load_q,  load_d;
    logic             busy_q,  busy_d;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    count;
    logic             terminal;
    logic             inc;

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // Data bits are not counted while waiting for the parity bit
    assign inc = bit_valid && !abort && (state_q != ST_PARITY);

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort),
        .inc      (inc),
        .count    (count),
        .terminal (terminal)
    );

    // Shift register contents after accepting serial_in, in the chosen bit order
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_next = {shift_q[WIDTH-2:0], serial_in};
        end else begin
            shift_next = {serial_in, shift_q[WIDTH-1:1]};
        end
    end

    // FSM, shift register and output word next-state logic
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        load_d  = 1'b0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (abort) begin
            // Abort beats any bit presented in the same cycle, even the last one
            state_d = ST_IDLE;
            shift_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    if (bit_valid) begin
                        shift_d = shift_next;
                        state_d = ST_SHIFT;
                        if (terminal) begin
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                            state_d = ST_PARITY;
`else
                            data_d  = shift_next;
                            load_d  = 1'b1;
                            shift_d = '0;
                            state_d = ST_IDLE;
`endif
                        end
                    end
                end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                ST_PARITY: begin
                    if (bit_valid) begin
                        // Even parity: XOR of data bits must equal the parity bit
                        if ((^shift_q) == serial_in) begin
                            data_d = shift_q;
                            load_d = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
                        shift_d = '0;
                        state_d = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    shift_d = '0;
                end
            endcase
        end
    end

    // Busy mirrors the counter's next value (nonzero) or a pending parity bit
    always_comb begin
        if (abort) begin
            busy_d = 1'b0;
        end else begin
            busy_d = (state_d == ST_PARITY) || (!terminal && (inc || (count != '0)));
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    // Parity error pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out = data_q;
    assign load     = load_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: an MSB-first and an LSB-first
// instance share the same serial stimulus.
module tb_serial_to_parallel;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_in;
    logic         bit_valid;
    logic         abort;
    logic [W-1:0] data_msb, data_lsb;
    logic         load_msb, load_lsb;
    logic         busy_msb, busy_lsb;
    logic         perr_msb, perr_lsb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .abort      (abort),
        .data_out   (data_msb),
        .load       (load_msb),
        .busy       (busy_msb),
        .parity_err (perr_msb)
    );

    serial_to_parallel #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .abort      (abort),
        .data_out   (data_lsb),
        .load       (load_lsb),
        .busy       (busy_lsb),
        .parity_err (perr_lsb)
    );

    // Apply inputs on the falling edge, return 1 ns after the next rising edge
    task automatic drive(input logic b, input logic v, input logic a);
        @(negedge clk);
        serial_in = b;
        bit_valid = v;
        abort     = a;
        @(posedge clk);
        #1;
    endtask

    // Send a byte MSB-first on consecutive cycles
    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            drive(w[7-i], 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; abort = 1'b0;
        #12;
        n_checks++;
        if ({data_msb, load_msb, busy_msb, perr_msb} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_msb: got data=%h load=%b busy=%b perr=%b, expected all 0",
                     data_msb, load_msb, busy_msb, perr_msb);
        end
        n_checks++;
        if ({data_lsb, load_lsb, busy_lsb, perr_lsb} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_lsb: got data=%h load=%b busy=%b perr=%b, expected all 0",
                     data_lsb, load_lsb, busy_lsb, perr_lsb);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'h55;
        for (int i = 0; i < 8; i++) begin
            drive(pat[7-i], 1'b1, 1'b0);
            n_checks++;
            if (load_msb !== (i == 7)) begin
                n_fail++;
                $display("FAIL basic_load bit %0d: got %b expected %b", i, load_msb, (i == 7));
            end
            n_checks++;
            if (busy_msb !== (i != 7)) begin
                n_fail++;
                $display("FAIL basic_busy bit %0d: got %b expected %b", i, busy_msb, (i != 7));
            end
        end
        n_checks++;
        if (data_msb !== 8'h55) begin
            n_fail++;
            $display("FAIL basic_data_msb: got %h expected 55", data_msb);
        end
        n_checks++;
        if (data_lsb !== 8'hAA) begin
            n_fail++;
            $display("FAIL basic_data_lsb: got %h expected aa", data_lsb);
        end
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({load_msb, busy_msb, data_msb} !== {1'b0, 1'b0, 8'h55}) begin
            n_fail++;
            $display("FAIL basic_after: got load=%b busy=%b data=%h expected 0 0 55",
                     load_msb, busy_msb, data_msb);
        end
        $display("basic: word msb=%h lsb=%h", data_msb, data_lsb);
    endtask

    task automatic test_gapped();
        logic [7:0] pat;
        pat = 8'h55;
        for (int i = 0; i < 8; i++) begin
            drive(pat[i], 1'b1, 1'b0);
            n_checks++;
            if (load_lsb !== (i == 7)) begin
                n_fail++;
                $display("FAIL gap_load bit %0d: got %b expected %b", i, load_lsb, (i == 7));
            end
            if (i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 1'b0, 1'b0);
                    n_checks++;
                    if ({load_lsb, busy_lsb} !== 2'b01) begin
                        n_fail++;
                        $display("FAIL gap_hold cycle %0d: got load=%b busy=%b expected 0 1",
                                 g, load_lsb, busy_lsb);
                    end
                end
            end
        end
        n_checks++;
        if (data_lsb !== 8'h55) begin
            n_fail++;
            $display("FAIL gap_data_lsb: got %h expected 55", data_lsb);
        end
        n_checks++;
        if (data_msb !== 8'hAA) begin
            n_fail++;
            $display("FAIL gap_data_msb: got %h expected aa", data_msb);
        end
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (load_lsb !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_single_pulse: got load=%b expected 0", load_lsb);
        end
        $display("gapped: word lsb=%h msb=%h", data_lsb, data_msb);
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        pat = 16'hAAFF;
        for (int i = 0; i < 16; i++) begin
            drive(pat[15-i], 1'b1, 1'b0);
            n_checks++;
            if ({load_msb, load_lsb} !== {2{(i == 7) || (i == 15)}}) begin
                n_fail++;
                $display("FAIL b2b_load bit %0d: got msb=%b lsb=%b expected %b",
                         i, load_msb, load_lsb, (i == 7) || (i == 15));
            end
            n_checks++;
            if (busy_msb !== ((i != 7) && (i != 15))) begin
                n_fail++;
                $display("FAIL b2b_busy bit %0d: got %b expected %b",
                         i, busy_msb, (i != 7) && (i != 15));
            end
            if (i == 7) begin
                n_checks++;
                if ({data_msb, data_lsb} !== 16'hAA55) begin
                    n_fail++;
                    $display("FAIL b2b_word1: got msb=%h lsb=%h expected aa 55", data_msb, data_lsb);
                end
            end
            if (i == 15) begin
                n_checks++;
                if ({data_msb, data_lsb} !== 16'hFFFF) begin
                    n_fail++;
                    $display("FAIL b2b_word2: got msb=%h lsb=%h expected ff ff", data_msb, data_lsb);
                end
            end
        end
        $display("back_to_back: final word msb=%h lsb=%h", data_msb, data_lsb);
    endtask

    task automatic test_abort();
        int loads;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({load_msb, busy_msb, data_msb} !== {1'b0, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL abort_mid: got load=%b busy=%b data=%h expected 0 0 ff",
                     load_msb, busy_msb, data_msb);
        end
        loads = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            loads += int'(load_msb);
        end
        drive(1'b0, 1'b0, 1'b0);
        loads += int'(load_msb);
        n_checks++;
        if (loads != 1 || data_msb !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_then_word: got loads=%0d data=%h expected 1 00", loads, data_msb);
        end
        // Abort on the completing edge drops the word
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({load_msb, busy_msb, data_msb} !== {1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL abort_last_edge: got load=%b busy=%b data=%h expected 0 0 00",
                     load_msb, busy_msb, data_msb);
        end
        $display("abort: word msb=%h", data_msb);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({data_msb, load_msb, busy_msb, data_lsb, busy_lsb} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset: got data=%h load=%b busy=%b lsb_data=%h lsb_busy=%b expected 0",
                     data_msb, load_msb, busy_msb, data_lsb, busy_lsb);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({load_msb, busy_msb, data_msb} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL async_after: got load=%b busy=%b data=%h expected 0 1 00",
                     load_msb, busy_msb, data_msb);
        end
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (busy_msb !== 1'b0) begin
            n_fail++;
            $display("FAIL async_cleanup: got busy=%b expected 0", busy_msb);
        end
        $display("async_reset: word msb=%h", data_msb);
    endtask

    task automatic test_parity();
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        send_word(8'h55);
        n_checks++;
        if ({load_msb, busy_msb} !== 2'b01) begin
            n_fail++;
            $display("FAIL par_wait: got load=%b busy=%b expected 0 1", load_msb, busy_msb);
        end
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({load_msb, perr_msb, data_msb} !== {1'b1, 1'b0, 8'h55}) begin
            n_fail++;
            $display("FAIL par_ok55: got load=%b perr=%b data=%h expected 1 0 55",
                     load_msb, perr_msb, data_msb);
        end
        send_word(8'hFF);
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({load_msb, perr_msb, data_msb} !== {1'b1, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL par_okff: got load=%b perr=%b data=%h expected 1 0 ff",
                     load_msb, perr_msb, data_msb);
        end
        send_word(8'h55);
        drive(1'b0, 1'b1, 1'b0);
        send_word(8'hFF);
        drive(1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({load_msb, perr_msb, busy_msb, data_msb} !== {1'b0, 1'b1, 1'b0, 8'h55}) begin
            n_fail++;
            $display("FAIL par_bad: got load=%b perr=%b busy=%b data=%h expected 0 1 0 55",
                     load_msb, perr_msb, busy_msb, data_msb);
        end
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (perr_msb !== 1'b0) begin
            n_fail++;
            $display("FAIL par_pulse: got perr=%b expected 0", perr_msb);
        end
`else
        send_word(8'h55);
        n_checks++;
        if ({load_msb, perr_msb, data_msb} !== {1'b1, 1'b0, 8'h55}) begin
            n_fail++;
            $display("FAIL nopar_55: got load=%b perr=%b data=%h expected 1 0 55",
                     load_msb, perr_msb, data_msb);
        end
        send_word(8'hFF);
        n_checks++;
        if ({load_msb, perr_msb, data_msb} !== {1'b1, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL nopar_ff: got load=%b perr=%b data=%h expected 1 0 ff",
                     load_msb, perr_msb, data_msb);
        end
`endif
        $display("parity: word msb=%h perr=%b", data_msb, perr_msb);
    endtask

    initial begin
        test_reset();
`ifndef SERIAL_TO_PARALLEL_PARITY_EN
        test_basic();
        test_gapped();
        test_back_to_back();
        test_abort();
`endif
        test_async_reset();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
